// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - two-player pong game controller on a 64x64 matrix
module pong_game_ctrl #(
    parameter int PADDLE_H    = 8,
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [5:0] bx,
    output logic [5:0] by,
    output logic [5:0] p1y,
    output logic [5:0] p2y,
    output logic [2:0] sc1,
    output logic [2:0] sc2,
    output logic [1:0] state,
    output logic       game_over,
    output logic       winner
);

    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

    localparam logic [5:0] PMAX = 6'(64 - PADDLE_H);
    localparam logic [5:0] PCEN = 6'((64 - PADDLE_H) / 2);
    localparam logic [2:0] WIN  = 3'(WIN_SCORE);
    localparam logic [7:0] SRV  = 8'(SERVE_TICKS);
    localparam logic [6:0] SPAN = 7'(PADDLE_H - 1);

    state_t     st;
    logic       dx, dy;
    logic [7:0] cnt;

    logic [5:0] n_p1, n_p2, v_by, h_bx;
    logic       v_dy, at_p1, at_p2, hit1, hit2, miss1, miss2;

    assign state     = st;
    assign game_over = (st == OVER);

    function automatic logic [5:0] paddle_next(input logic [5:0] y, input logic up, input logic dn);
        if (up && !dn) return (y == 6'd0) ? y : y - 6'd1;
        if (dn && !up) return (y >= PMAX) ? PMAX : y + 6'd1;
        return y;
    endfunction

    function automatic logic in_paddle(input logic [5:0] p, input logic [5:0] y);
        return ({1'b0, y} >= {1'b0, p}) && ({1'b0, y} <= ({1'b0, p} + SPAN));
    endfunction

    // Vertical and horizontal motion are resolved independently so a corner
    // arrival bounces off the wall and is hit-tested in the same tick.
    always_comb begin
        n_p1  = paddle_next(p1y, p1_up, p1_dn);
        n_p2  = paddle_next(p2y, p2_up, p2_dn);
        v_dy  = dy;
        v_by  = dy ? by + 6'd1 : by - 6'd1;
        if (!dy && by == 6'd0) begin
            v_dy = 1'b1;
            v_by = 6'd1;
        end else if (dy && by == 6'd63) begin
            v_dy = 1'b0;
            v_by = 6'd62;
        end
        at_p1 = !dx && bx == 6'd2;
        at_p2 = dx && bx == 6'd61;
        hit1  = in_paddle(p1y, by);
        hit2  = in_paddle(p2y, by);
        miss1 = at_p1 && !hit1;
        miss2 = at_p2 && !hit2;
        h_bx  = dx ? bx + 6'd1 : bx - 6'd1;
        if (at_p1) h_bx = 6'd3;
        if (at_p2) h_bx = 6'd60;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            bx     <= 6'd32;
            by     <= 6'd32;
            p1y    <= PCEN;
            p2y    <= PCEN;
            sc1    <= 3'd0;
            sc2    <= 3'd0;
            winner <= 1'b0;
            dx     <= 1'b1;
            dy     <= 1'b1;
            cnt    <= 8'd0;
        end else begin
            case (st)
                IDLE: if (start) begin
                    st  <= SERVE;
                    cnt <= 8'd0;
                    dx  <= 1'b1;
                    dy  <= 1'b1;
                end
                SERVE: if (tick) begin
                    p1y <= n_p1;
                    p2y <= n_p2;
                    cnt <= cnt + 8'd1;
                    if (cnt + 8'd1 == SRV) st <= PLAY;
                end
                PLAY: if (tick) begin
                    p1y <= n_p1;
                    p2y <= n_p2;
                    if (miss1 || miss2) begin
                        bx  <= 6'd32;
                        by  <= 6'd32;
                        dy  <= 1'b1;
                        dx  <= miss2;
                        cnt <= 8'd0;
                        st  <= SERVE;
                        if (miss1) begin
                            sc2 <= sc2 + 3'd1;
                            if (sc2 + 3'd1 == WIN) begin
                                st     <= OVER;
                                winner <= 1'b1;
                            end
                        end else begin
                            sc1 <= sc1 + 3'd1;
                            if (sc1 + 3'd1 == WIN) begin
                                st     <= OVER;
                                winner <= 1'b0;
                            end
                        end
                    end else begin
                        bx <= h_bx;
                        by <= v_by;
                        dy <= v_dy;
                        if (at_p1) dx <= 1'b1;
                        if (at_p2) dx <= 1'b0;
                    end
                end
                OVER: if (start) begin
                    st  <= SERVE;
                    sc1 <= 3'd0;
                    sc2 <= 3'd0;
                    bx  <= 6'd32;
                    by  <= 6'd32;
                    p1y <= PCEN;
                    p2y <= PCEN;
                    dx  <= 1'b1;
                    dy  <= 1'b1;
                    cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule
